// File: rtl/fb_writer_pkg.sv
// -----------------------------------------------------------------------------
// fb_writer_pkg
// Shared framebuffer definitions: default raster size, framebuffer address and
// pixel widths, and the writer state encoding. Imported by the framebuffer
// writer and by the display stage that reads the same framebuffer.
// -----------------------------------------------------------------------------
package fb_writer_pkg;

    // Default active raster (640x480)
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    // Framebuffer port widths: 19-bit word address, 12-bit RGB444 pixel
    localparam int unsigned FB_ADDR_W = 19;
    localparam int unsigned FB_PIX_W  = 12;

    // Writer states
    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        WRITE    = 2'd1,
        DISCARD  = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// -----------------------------------------------------------------------------
// fb_addr_gen
// Column/row counters and framebuffer address generation for the writer.
// The line base address is kept in a running register (base += H_ACTIVE on
// each new line), so no multiplier is needed.
//
// Ports:
//   CLK100MHZ  in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   clear      in   restart at col 0 / row 0 before applying advances
//   adv_col    in   step to the next column
//   adv_row    in   step to column 0 of the next row (wraps after last row)
//   addr       out  current write address = base + col
//   col_last   out  current column is H_ACTIVE-1
//   row_last   out  current row is V_ACTIVE-1
// -----------------------------------------------------------------------------
module fb_addr_gen
    import fb_writer_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 adv_col,
    input  logic                 adv_row,
    output logic [FB_ADDR_W-1:0] addr,
    output logic                 col_last,
    output logic                 row_last
);

    localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);
    localparam int unsigned ROW_W = $clog2(V_ACTIVE + 1);

    localparam logic [COL_W-1:0]     COL_LAST    = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0]     ROW_LAST    = ROW_W'(V_ACTIVE - 1);
    localparam logic [FB_ADDR_W-1:0] LINE_STRIDE = FB_ADDR_W'(H_ACTIVE);

    logic [COL_W-1:0]     col, col_start, col_nxt;
    logic [ROW_W-1:0]     row, row_start, row_nxt;
    logic [FB_ADDR_W-1:0] base, base_start, base_nxt;

    // Counter update. A clear is applied first so that a start-of-frame pixel
    // can restart the raster and advance in the same cycle (sof+eol lands on
    // row 1, plain sof lands on col 1).
    always_comb begin
        col_start  = clear ? '0 : col;
        row_start  = clear ? '0 : row;
        base_start = clear ? '0 : base;

        col_nxt  = col_start;
        row_nxt  = row_start;
        base_nxt = base_start;

        if (adv_row) begin
            col_nxt = '0;
            if (row_start == ROW_LAST) begin
                row_nxt  = '0;
                base_nxt = '0;
            end else begin
                row_nxt  = row_start + ROW_W'(1);
                base_nxt = base_start + LINE_STRIDE;
            end
        end else if (adv_col) begin
            col_nxt = col_start + COL_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            col  <= '0;
            row  <= '0;
            base <= '0;
        end else begin
            col  <= col_nxt;
            row  <= row_nxt;
            base <= base_nxt;
        end
    end

    assign addr     = base + FB_ADDR_W'(col);
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);

endmodule

// File: rtl/fb_writer.sv
// -----------------------------------------------------------------------------
// fb_writer
// Accepts a raster pixel stream (valid/ready with sof/eol markers) and writes
// it into a linear framebuffer, one registered write per accepted pixel.
// Short and long lines are flagged and realigned at the next eol; an early
// sof abandons the current frame and restarts at address 0.
//
// Ports:
//   CLK100MHZ   in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   enable      in   1 = accept pixels, 0 = stall
//   fb_busy     in   framebuffer write port unavailable this cycle
//   s_valid     in   upstream pixel valid
//   s_ready     out  enable & ~fb_busy (combinational)
//   s_data      in   pixel {R[11:8], G[7:4], B[3:0]}
//   s_sof       in   first pixel of frame
//   s_eol       in   last pixel of line
//   waddr_fb    out  framebuffer write address (registered)
//   wdata_fb    out  framebuffer write data (registered)
//   we_fb       out  write strobe, one cycle per write (registered)
//   frame_done  out  pulse when the last line of the frame completes
//   err_line    out  pulse on a short or long line
//   err_frame   out  pulse on sof before frame completion
// -----------------------------------------------------------------------------
module fb_writer
    import fb_writer_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fb_busy,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [FB_PIX_W-1:0]  s_data,
    input  logic                 s_sof,
    input  logic                 s_eol,
    output logic [FB_ADDR_W-1:0] waddr_fb,
    output logic [FB_PIX_W-1:0]  wdata_fb,
    output logic                 we_fb,
    output logic                 frame_done,
    output logic                 err_line,
    output logic                 err_frame
);

    // A sof pixel always sits at col 0 / row 0; these tell whether that
    // position is already the end of a line or of the frame.
    localparam logic SOF_COL_LAST = (H_ACTIVE == 1);
    localparam logic SOF_ROW_LAST = (V_ACTIVE == 1);

    fb_state_t            state, state_nxt;
    logic                 xfer;
    logic                 writing;
    logic                 col_last, row_last;
    logic                 col_last_eff, row_last_eff;
    logic                 clear, adv_col, adv_row;
    logic                 do_write;
    logic                 fd_nxt, el_nxt, ef_nxt;
    logic [FB_ADDR_W-1:0] addr;

    assign s_ready = enable & ~fb_busy;
    assign xfer    = s_valid & s_ready;

    fb_addr_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_addr_gen (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .clear     (clear),
        .adv_col   (adv_col),
        .adv_row   (adv_row),
        .addr      (addr),
        .col_last  (col_last),
        .row_last  (row_last)
    );

    // Next-state and counter control. Nothing moves without a transfer.
    // A sof pixel is written in every state and is evaluated as if the
    // counters had already been cleared, so sof+eol behaves as sof then eol.
    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        clear     = 1'b0;
        adv_col   = 1'b0;
        adv_row   = 1'b0;
        fd_nxt    = 1'b0;
        el_nxt    = 1'b0;
        ef_nxt    = 1'b0;

        col_last_eff = s_sof ? SOF_COL_LAST : col_last;
        row_last_eff = s_sof ? SOF_ROW_LAST : row_last;
        writing      = s_sof | (state == WRITE);

        if (xfer && writing) begin
            do_write = 1'b1;
            clear    = s_sof;
            ef_nxt   = s_sof && (state != WAIT_SOF);
            if (s_eol) begin
                el_nxt  = !col_last_eff;
                adv_row = 1'b1;
                if (row_last_eff) begin
                    fd_nxt    = 1'b1;
                    state_nxt = WAIT_SOF;
                end else begin
                    state_nxt = WRITE;
                end
            end else if (col_last_eff) begin
                // Line ran past its last column: drop the rest until eol
                el_nxt    = 1'b1;
                state_nxt = DISCARD;
            end else begin
                adv_col   = 1'b1;
                state_nxt = WRITE;
            end
        end else if (xfer && (state == DISCARD) && s_eol) begin
            adv_row = 1'b1;
            if (row_last) begin
                fd_nxt    = 1'b1;
                state_nxt = WAIT_SOF;
            end else begin
                state_nxt = WRITE;
            end
        end
    end

    // State register
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_nxt;
        end
    end

    // Framebuffer write port and status pulses, one cycle after the transfer.
    // Address and data hold their last value between writes.
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            waddr_fb   <= '0;
            wdata_fb   <= '0;
            we_fb      <= 1'b0;
            frame_done <= 1'b0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            we_fb      <= do_write;
            frame_done <= fd_nxt;
            err_line   <= el_nxt;
            err_frame  <= ef_nxt;
            if (do_write) begin
                waddr_fb <= s_sof ? '0 : addr;
                wdata_fb <= s_data;
            end
        end
    end

endmodule
